// File: rtl/mem_ctrl_pkg.sv
// Shared helpers for the memory-control blocks: address-width sizing and
// one-hot to binary index conversion.
package mem_ctrl_pkg;

    // Address width needed to index 'depth' words; never less than one bit.
    function automatic int addr_w(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end
        return 1;
    endfunction

    // Binary index of the set bit of a one-hot vector (up to 32 bits wide).
    // An all-zero input yields index 0.
    function automatic int unsigned onehot_to_index(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | 32'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/decoder_logN_to_N.sv
// Binary address to one-hot word-enable decoder for an N-word array.
// Addresses at or beyond N decode to all zeros.
module decoder_logN_to_N
    import mem_ctrl_pkg::*;
#(
    parameter  int N  = 8,
    localparam int AW = addr_w(N)
) (
    input  logic [AW-1:0] addr,
    input  logic          en,
    output logic [N-1:0]  dec
);

    // One enable per word, raised only when enabled and the address matches.
    always_comb begin
        dec = '0;
        for (int i = 0; i < N; i++) begin
            dec[i] = en && (addr == AW'(i));
        end
    end

endmodule

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: finds the first eligible requester at or
// above ptr, wrapping around, using a doubled request vector so the wrap
// is just a plain find-first over 2*NREQ bits.
module rr_priority_pick
    import mem_ctrl_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant_oh,
    output logic [PW-1:0]   grant_idx,
    output logic            valid
);

    logic [2*NREQ-1:0] doubled;
    logic [2*NREQ-1:0] masked;
    logic              found;
    int                first;

    // Mask away positions below ptr in the doubled vector and take the
    // lowest survivor; its position modulo NREQ is the winner.
    always_comb begin
        doubled = {eligible, eligible};
        masked  = '0;
        found   = 1'b0;
        first   = 0;
        for (int i = 0; i < 2*NREQ; i++) begin
            masked[i] = doubled[i] && (i >= int'(ptr));
        end
        for (int i = 0; i < 2*NREQ; i++) begin
            if (!found && masked[i]) begin
                found = 1'b1;
                first = i;
            end
        end
        grant_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_oh[i] = found && ((first == i) || (first == i + NREQ));
        end
        grant_idx = PW'(onehot_to_index(32'(grant_oh)));
        valid     = found;
    end

endmodule

// File: rtl/mem_write_arbiter.sv
// Round-robin arbiter sharing one memory write port among NREQ requesters.
// The winning request's address, data and acknowledge are registered; the
// registered address drives the word-enable decoder so ack and wr_en are
// coincident one cycle after the request is sampled.
module mem_write_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = addr_w(DEPTH),
    localparam int PW    = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    output logic [DEPTH-1:0]   wr_en,
    output logic [WIDTH-1:0]   wr_data,
    output logic               addr_err,
    output logic               busy
);

    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  pick_oh;
    logic [PW-1:0]    pick_idx;
    logic             pick_valid;
    logic             grant;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic             in_range;

    logic [PW-1:0]    ptr_q,      ptr_d;
    logic [NREQ-1:0]  ack_q,      ack_d;
    logic [WIDTH-1:0] wr_data_q,  wr_data_d;
    logic             addr_err_q, addr_err_d;
    logic [AW-1:0]    dec_addr_q, dec_addr_d;
    logic             dec_en_q,   dec_en_d;

    // A requester whose ack is showing this cycle still has req high, so it
    // is masked out to avoid granting the same write twice.
    assign eligible = req & ~ack_q;
    assign busy     = |eligible;

    rr_priority_pick #(.NREQ(NREQ)) u_pick (
        .eligible  (eligible),
        .ptr       (ptr_q),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .valid     (pick_valid)
    );

    // Route the winner's address and data out of the packed request buses.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
        in_range = 32'(sel_addr) < 32'(DEPTH);
    end

    // Next-state: a grant loads ack/data/address and advances the pointer
    // past the winner; otherwise strobes clear and data/pointer hold.
    always_comb begin
        grant      = pick_valid && !hold;
        ack_d      = '0;
        addr_err_d = 1'b0;
        dec_en_d   = 1'b0;
        dec_addr_d = dec_addr_q;
        wr_data_d  = wr_data_q;
        ptr_d      = ptr_q;
        if (grant) begin
            ack_d      = pick_oh;
            wr_data_d  = sel_data;
            dec_addr_d = sel_addr;
            dec_en_d   = in_range;
            addr_err_d = !in_range;
            if (32'(pick_idx) == 32'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_idx + 1'b1;
            end
        end
    end

    // All arbiter state, cleared asynchronously so outputs drop at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            ack_q      <= '0;
            wr_data_q  <= '0;
            addr_err_q <= 1'b0;
            dec_addr_q <= '0;
            dec_en_q   <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            wr_data_q  <= wr_data_d;
            addr_err_q <= addr_err_d;
            dec_addr_q <= dec_addr_d;
            dec_en_q   <= dec_en_d;
        end
    end

    decoder_logN_to_N #(.N(DEPTH)) u_dec (
        .addr (dec_addr_q),
        .en   (dec_en_q),
        .dec  (wr_en)
    );

    assign ack      = ack_q;
    assign wr_data  = wr_data_q;
    assign addr_err = addr_err_q;

endmodule
